gated_mux_activity_mon: RTL and testbench
=========================================

Name: gated_mux_activity_mon

Overview:
Parametrised, registered successor to the single-bit gated 2:1 mux power sub-circuit. The datapath generalises out = ~kill & (sel ? a : b) to WIDTH bits and registers the result. A built-in switching-activity monitor counts output bit toggles over fixed windows and reports each window total over a valid/ready handshake. The block sits in the power-experiment sub-circuit set as a measurable toggle source and monitor.

Parameters:
WIDTH, 8, datapath width in bits (>=1)
WINDOW, 256, measurement window length in clock cycles (>=2)
CNT_W, 16, toggle accumulator and report width in bits; the accumulator saturates

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  datapath update enable
kill  input  1  forces the output to zero when high
sel  input  1  1 selects a, 0 selects b
a  input  WIDTH  operand A
b  input  WIDTH  operand B
clear  input  1  synchronous clear of the monitor only
out_data  output  WIDTH  registered mux result
out_valid  output  1  registered copy of in_valid
rpt_valid  output  1  window report available
rpt_ready  input  1  consumer accepts the report
rpt_count  output  CNT_W  toggle total for the reported window
rpt_sat  output  1  the reported window saturated
rpt_overrun  output  1  sticky: an unaccepted report was overwritten

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs, accumulator, window counter and FSM go to 0/ACCUM. This applies mid-window and mid-report; any pending report is discarded.
- Datapath, latency 1: when in_valid=1, out_data <= kill ? 0 : (sel ? a : b). When in_valid=0, out_data holds. out_valid <= in_valid every cycle.
- Toggle increment per cycle: inc = popcount(next_out ^ out_data) when in_valid=1, else 0.
- Accumulator: acc <= min(acc + inc, 2^CNT_W - 1). The addition is computed at CNT_W+log2(WIDTH)+1 bits. sat_w is a sticky flag, set when the sum exceeds the maximum.
- Window counter wcnt runs 0..WINDOW-1 on every cycle, independent of in_valid, and wraps. The terminal cycle is wcnt=WINDOW-1.
- At the terminal cycle:
  - snapshot = saturated acc+inc, including the terminal cycle's contribution;
  - acc <= 0 and sat_w <= 0 for the new window;
  - accumulation never pauses.
- FSM states:
  - ACCUM: rpt_valid=0. On terminal: rpt_count <= snapshot, rpt_sat <= sat, rpt_valid <= 1, go to REPORT.
  - REPORT: rpt_valid=1; rpt_count and rpt_sat are held stable.
    - rpt_ready=1 and no terminal: rpt_valid <= 0, go to ACCUM.
    - Terminal and rpt_ready=1 in the same cycle: load the new snapshot, stay in REPORT, no overrun.
    - Terminal and rpt_ready=0: overwrite with the new snapshot, stay in REPORT, set rpt_overrun.
- clear=1 (synchronous): acc, sat_w, wcnt, rpt_valid, rpt_count, rpt_sat and rpt_overrun go to 0; FSM goes to ACCUM. The datapath is unaffected. clear has priority over a terminal event in the same cycle. rst_n has priority over clear.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Mux function (WIDTH=8): a=0xA5, b=0x3C, in_valid=1, kill=0, sel=1 -> out_data=0xA5 next cycle. sel=0 -> 0x3C. kill=1 -> 0x00. in_valid=0 -> holds the last value, out_valid=0.
2. Toggle count (WINDOW=4, CNT_W=16): out starts at 0x00; drive sel=1 with a alternating 0xFF,0x00,0xFF,0x00 on wcnt 0..3 -> rpt_valid=1 the cycle after wcnt=3, rpt_count=32, rpt_sat=0.
3. Saturation (CNT_W=4, same stimulus as test 2) -> rpt_count=15, rpt_sat=1. The next quiet window (in_valid=0) reports rpt_count=0, rpt_sat=0.
4. Backpressure (WINDOW=4): rpt_ready=0 across two terminals -> the second snapshot replaces the first and rpt_overrun=1. Repeat with rpt_ready=1 exactly on the second terminal cycle -> new report loaded, rpt_valid stays 1, rpt_overrun=0.
5. clear at wcnt=2 -> the next report arrives 4 cycles after clear and counts only post-clear toggles. clear asserted on a terminal cycle -> no report.
6. rst_n=0 for 1 cycle while rpt_valid=1 and traffic is running -> every output is 0 at the following edge, and the first report arrives exactly WINDOW cycles after release.

Source files
------------

// File: rtl/gated_mux_activity_mon.sv
// gated_mux_activity_mon: registered WIDTH-bit gated 2:1 mux with a windowed output-toggle monitor and report handshake
module gated_mux_activity_mon #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             kill,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clear,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_overrun
);
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = CNT_W + $clog2(WIDTH) + 1;
    localparam int WC_W  = $clog2(WINDOW);

    typedef enum logic {ACCUM, REPORT} state_t;

    state_t           state;
    logic [WIDTH-1:0] next_out;
    logic [PC_W-1:0]  inc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] snapshot;
    logic [WC_W-1:0]  wcnt;
    logic             sat_w;
    logic             over;
    logic             terminal;

    // holding the output when in_valid=0 makes the toggle increment zero for free
    assign next_out = in_valid ? (kill ? '0 : (sel ? a : b)) : out_data;

    // popcount of the output bits that flip at the coming edge
    always_comb begin
        inc = '0;
        for (int i = 0; i < WIDTH; i++) inc = inc + PC_W'(next_out[i] ^ out_data[i]);
    end

    assign sum      = SUM_W'(acc) + SUM_W'(inc);
    assign over     = sum > SUM_W'({CNT_W{1'b1}});
    assign snapshot = over ? '1 : sum[CNT_W-1:0];
    assign terminal = wcnt == WC_W'(WINDOW - 1);

    // registered gated mux datapath; clear leaves it untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_data  <= next_out;
            out_valid <= in_valid;
        end
    end

    // window counter and saturating accumulator; a new window starts empty after the terminal cycle
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wcnt  <= '0;
            acc   <= '0;
            sat_w <= 1'b0;
        end else begin
            wcnt  <= terminal ? '0 : wcnt + 1'b1;
            acc   <= terminal ? '0 : snapshot;
            sat_w <= terminal ? 1'b0 : (sat_w | over);
        end
    end

    // report FSM: a terminal always loads a fresh report, overrun flags a lost unaccepted one
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state       <= ACCUM;
            rpt_valid   <= 1'b0;
            rpt_count   <= '0;
            rpt_sat     <= 1'b0;
            rpt_overrun <= 1'b0;
        end else if (terminal) begin
            state     <= REPORT;
            rpt_valid <= 1'b1;
            rpt_count <= snapshot;
            rpt_sat   <= sat_w | over;
            if (state == REPORT && !rpt_ready) rpt_overrun <= 1'b1;
        end else if (state == REPORT && rpt_ready) begin
            state     <= ACCUM;
            rpt_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gated_mux_activity_mon.sv
// tb_gated_mux_activity_mon: randomized bench for the gated mux and toggle monitor against a raw-toggle-count model
module tb_gated_mux_activity_mon;
    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, kill = 1'b0, sel = 1'b0, clear = 1'b0, rpt_ready = 1'b0;
    logic [7:0]  a = 8'h00, b = 8'h00;
    logic [7:0]  out_data, s_out_data;
    logic        out_valid, rpt_valid, rpt_sat, rpt_overrun;
    logic        s_out_valid, s_rpt_valid, s_rpt_sat, s_rpt_overrun;
    logic [15:0] rpt_count;
    logic [3:0]  s_rpt_count;

    // model state: raw toggle total per window, saturation applied only when a report is formed
    logic [7:0]  m_out = 8'h00;
    logic        m_ov = 1'b0, m_rv = 1'b0, m_rs16 = 1'b0, m_rs4 = 1'b0, m_ovr = 1'b0;
    logic [15:0] m_rc16 = 16'h0;
    logic [3:0]  m_rc4 = 4'h0;
    int          m_tog = 0, m_phase = 0;
    int          pass_cnt = 0, total_cnt = 0;

    wire [27:0] obs16 = {out_data, out_valid, rpt_valid, rpt_count, rpt_sat, rpt_overrun};
    wire [27:0] exp16 = {m_out, m_ov, m_rv, m_rc16, m_rs16, m_ovr};
    wire [15:0] obs4  = {s_out_data, s_out_valid, s_rpt_valid, s_rpt_count, s_rpt_sat, s_rpt_overrun};
    wire [15:0] exp4  = {m_out, m_ov, m_rv, m_rc4, m_rs4, m_ovr};

    always #5 clk = ~clk;

    gated_mux_activity_mon #(.WIDTH(8), .WINDOW(WIN), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .kill(kill), .sel(sel), .a(a), .b(b),
        .clear(clear), .out_data(out_data), .out_valid(out_valid), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_count(rpt_count), .rpt_sat(rpt_sat), .rpt_overrun(rpt_overrun)
    );

    gated_mux_activity_mon #(.WIDTH(8), .WINDOW(WIN), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .kill(kill), .sel(sel), .a(a), .b(b),
        .clear(clear), .out_data(s_out_data), .out_valid(s_out_valid), .rpt_valid(s_rpt_valid),
        .rpt_ready(rpt_ready), .rpt_count(s_rpt_count), .rpt_sat(s_rpt_sat), .rpt_overrun(s_rpt_overrun)
    );

    // advance the model by one clock using the current inputs, then step past the edge
    task automatic tick();
        logic [7:0] nxt;
        int tot;
        if (!rst_n) begin
            m_out = 8'h00; m_ov = 1'b0; m_rv = 1'b0; m_rc16 = 16'h0; m_rs16 = 1'b0;
            m_rc4 = 4'h0; m_rs4 = 1'b0; m_ovr = 1'b0; m_tog = 0; m_phase = 0;
        end else begin
            nxt = in_valid ? (kill ? 8'h00 : (sel ? a : b)) : m_out;
            tot = m_tog + $countones(nxt ^ m_out);
            if (clear) begin
                m_tog = 0; m_phase = 0; m_rv = 1'b0; m_rc16 = 16'h0; m_rs16 = 1'b0;
                m_rc4 = 4'h0; m_rs4 = 1'b0; m_ovr = 1'b0;
            end else if (m_phase == WIN - 1) begin
                if (m_rv && !rpt_ready) m_ovr = 1'b1;
                m_rv   = 1'b1;
                m_rc16 = tot > 65535 ? 16'hFFFF : 16'(tot);
                m_rs16 = tot > 65535;
                m_rc4  = tot > 15 ? 4'hF : 4'(tot);
                m_rs4  = tot > 15;
                m_tog  = 0;
                m_phase = 0;
            end else begin
                if (m_rv && rpt_ready) m_rv = 1'b0;
                m_tog = tot;
                m_phase++;
            end
            m_out = nxt;
            m_ov  = in_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_in();
        in_valid = ($urandom_range(0, 3) != 0);
        kill     = ($urandom_range(0, 7) == 0);
        sel      = 1'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rand_in();
        tick();
        tick();
        total_cnt++;
        if (obs16 !== 28'h0) $display("FAIL reset16 got %h want %h", obs16, 28'h0); else pass_cnt++;
        total_cnt++;
        if (obs4 !== 16'h0) $display("FAIL reset4 got %h want %h", obs4, 16'h0); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_mux();
        logic [7:0] want [4] = '{8'hA5, 8'h3C, 8'h00, 8'h00};
        a = 8'hA5; b = 8'h3C; rpt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i != 3);
            sel      = (i == 0);
            kill     = (i == 2);
            tick();
            total_cnt++;
            if (out_data !== want[i] || out_valid !== (i != 3))
                $display("FAIL mux%0d got %h/%b want %h/%b", i, out_data, out_valid, want[i], i != 3);
            else pass_cnt++;
        end
        a = 8'h5A;
        tick();
        total_cnt++;
        if (out_data !== 8'h00 || obs16 !== exp16) $display("FAIL mux_hold got %h want %h", obs16, exp16); else pass_cnt++;
    endtask

    task automatic test_toggle_sat();
        clear = 1'b1; in_valid = 1'b1; kill = 1'b1; rpt_ready = 1'b0;
        tick();
        clear = 1'b0; kill = 1'b0; sel = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            a = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            if (i == WIN - 2) begin
                total_cnt++;
                if (rpt_valid !== 1'b0) $display("FAIL tog_early got %b want 0", rpt_valid); else pass_cnt++;
            end
        end
        total_cnt++;
        if (rpt_valid !== 1'b1 || rpt_count !== 16'd32 || rpt_sat !== 1'b0)
            $display("FAIL tog_count got %b/%0d/%b want 1/32/0", rpt_valid, rpt_count, rpt_sat);
        else pass_cnt++;
        total_cnt++;
        if (s_rpt_valid !== 1'b1 || s_rpt_count !== 4'd15 || s_rpt_sat !== 1'b1)
            $display("FAIL sat_count got %b/%0d/%b want 1/15/1", s_rpt_valid, s_rpt_count, s_rpt_sat);
        else pass_cnt++;
        total_cnt++;
        if (obs16 !== exp16 || obs4 !== exp4) $display("FAIL tog_model got %h %h want %h %h", obs16, obs4, exp16, exp4); else pass_cnt++;
        in_valid = 1'b0; rpt_ready = 1'b1;
        tick();
        total_cnt++;
        if (rpt_valid !== 1'b0) $display("FAIL tog_accept got %b want 0", rpt_valid); else pass_cnt++;
        for (int i = 1; i < WIN; i++) tick();
        total_cnt++;
        if (s_rpt_valid !== 1'b1 || s_rpt_count !== 4'd0 || s_rpt_sat !== 1'b0 || rpt_count !== 16'd0)
            $display("FAIL quiet got %b/%0d/%b/%0d want 1/0/0/0", s_rpt_valid, s_rpt_count, s_rpt_sat, rpt_count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        clear = 1'b1; rpt_ready = 1'b0;
        rand_in();
        tick();
        clear = 1'b0;
        for (int i = 0; i < 2 * WIN; i++) begin rand_in(); tick(); end
        total_cnt++;
        if (rpt_valid !== 1'b1 || rpt_overrun !== 1'b1 || obs16 !== exp16 || obs4 !== exp4)
            $display("FAIL overrun got %h %h want %h %h", obs16, obs4, exp16, exp4);
        else pass_cnt++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 2 * WIN; i++) begin
            rand_in();
            rpt_ready = (i == 2 * WIN - 1);
            tick();
        end
        total_cnt++;
        if (rpt_valid !== 1'b1 || rpt_overrun !== 1'b0 || obs16 !== exp16 || obs4 !== exp4)
            $display("FAIL ready_on_term got %h %h want %h %h", obs16, obs4, exp16, exp4);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        rpt_ready = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_in(); tick(); end
        clear = 1'b1;
        rand_in();
        tick();
        clear = 1'b0;
        for (int i = 0; i < WIN - 1; i++) begin rand_in(); tick(); end
        total_cnt++;
        if (rpt_valid !== 1'b0) $display("FAIL clear_early got %b want 0", rpt_valid); else pass_cnt++;
        rand_in();
        tick();
        total_cnt++;
        if (rpt_valid !== 1'b1 || obs16 !== exp16 || obs4 !== exp4)
            $display("FAIL clear_report got %h %h want %h %h", obs16, obs4, exp16, exp4);
        else pass_cnt++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < WIN - 1; i++) begin rand_in(); tick(); end
        clear = 1'b1;
        rand_in();
        tick();
        clear = 1'b0;
        total_cnt++;
        if (rpt_valid !== 1'b0 || obs16 !== exp16) $display("FAIL clear_term got %h want %h", obs16, exp16); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rpt_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < WIN + 1; i++) begin rand_in(); tick(); end
        total_cnt++;
        if (rpt_valid !== 1'b1) $display("FAIL pre_reset got %b want 1", rpt_valid); else pass_cnt++;
        rst_n = 1'b0;
        rand_in();
        tick();
        total_cnt++;
        if (obs16 !== 28'h0 || obs4 !== 16'h0) $display("FAIL mid_reset got %h %h want 0 0", obs16, obs4); else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < WIN - 1; i++) begin rand_in(); tick(); end
        total_cnt++;
        if (rpt_valid !== 1'b0) $display("FAIL post_reset_early got %b want 0", rpt_valid); else pass_cnt++;
        rand_in();
        tick();
        total_cnt++;
        if (rpt_valid !== 1'b1 || obs16 !== exp16 || obs4 !== exp4)
            $display("FAIL post_reset_report got %h %h want %h %h", obs16, obs4, exp16, exp4);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_in();
            rpt_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
            total_cnt++;
            if (obs16 !== exp16 || obs4 !== exp4)
                $display("FAIL random%0d got %h %h want %h %h", i, obs16, obs4, exp16, exp4);
            else pass_cnt++;
        end
        rst_n = 1'b1; clear = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_mux();
        test_toggle_sat();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
